// File: rtl/ddr3_user_port_arbiter.sv
// Two-port round-robin arbiter in front of the DDR3 controller user interface.
// Holds the enable until the controller confirms, then returns read data tagged with the port id.
module ddr3_user_port_arbiter #(
  parameter int unsigned ADDRESS_BITWIDTH      = 15,
  parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
  parameter int unsigned DQ_BITWIDTH           = 8,
  parameter int unsigned STATE_BITWIDTH        = 5,
  parameter int unsigned STATE_WRITE_DATA      = 8,
  parameter int unsigned STATE_READ_DATA       = 11,
  parameter int unsigned READ_DATA_DELAY       = 4,
  parameter int unsigned TIMEOUT_CYCLES        = 1023
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              a_valid,
  input  logic                                              a_write,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] a_address,
  input  logic [DQ_BITWIDTH-1:0]                            a_wdata,
  output logic                                              a_ready,
  input  logic                                              b_valid,
  input  logic                                              b_write,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] b_address,
  input  logic [DQ_BITWIDTH-1:0]                            b_wdata,
  output logic                                              b_ready,
  output logic                                              rsp_valid,
  output logic                                              rsp_id,
  output logic [DQ_BITWIDTH-1:0]                            rsp_data,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  input  logic [STATE_BITWIDTH-1:0]                         main_state,
  output logic                                              busy,
  output logic                                              timeout_error
);

  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned DelayW   = $clog2(READ_DATA_DELAY + 1);

  localparam logic [TimeoutW-1:0]       TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
  localparam logic [DelayW-1:0]         DelayLast   = DelayW'(READ_DATA_DELAY - 1);
  localparam logic [STATE_BITWIDTH-1:0] StateWrite  = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] StateRead   = STATE_BITWIDTH'(STATE_READ_DATA);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitData, StRespond} state_e;

  state_e              state_q;
  logic                last_grant_q;  // 0 = A, 1 = B
  logic                id_q;
  logic [TimeoutW-1:0] wait_cnt_q;
  logic [DelayW-1:0]   delay_cnt_q;
  logic                grant_a;
  logic                grant_b;
  logic                grant_write;

  // On a tie the port that was not granted last wins.
  always_comb begin
    grant_a     = a_valid & (~b_valid | last_grant_q);
    grant_b     = b_valid & (~a_valid | ~last_grant_q);
    grant_write = grant_b ? b_write : a_write;
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q             <= StIdle;
      last_grant_q        <= 1'b1;
      id_q                <= 1'b0;
      wait_cnt_q          <= '0;
      delay_cnt_q         <= '0;
      a_ready             <= 1'b0;
      b_ready             <= 1'b0;
      rsp_valid           <= 1'b0;
      rsp_id              <= 1'b0;
      rsp_data            <= '0;
      write_enable        <= 1'b0;
      read_enable         <= 1'b0;
      i_user_data_address <= '0;
      data_to_ram         <= '0;
      timeout_error       <= 1'b0;
    end else begin
      a_ready   <= 1'b0;
      b_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_a || grant_b) begin
            a_ready             <= grant_a;
            b_ready             <= grant_b;
            id_q                <= grant_b;
            last_grant_q        <= grant_b;
            i_user_data_address <= grant_b ? b_address : a_address;
            data_to_ram         <= grant_b ? b_wdata : a_wdata;
            write_enable        <= grant_write;
            read_enable         <= ~grant_write;
            wait_cnt_q          <= '0;
            state_q             <= StIssue;
          end
        end
        StIssue: begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
          // Confirmation takes priority over a timeout on the same cycle.
          if (write_enable && (main_state == StateWrite)) begin
            write_enable <= 1'b0;
            state_q      <= StIdle;
          end else if (read_enable && (main_state == StateRead)) begin
            read_enable <= 1'b0;
            delay_cnt_q <= '0;
            state_q     <= StWaitData;
          end else if (wait_cnt_q == TimeoutLast) begin
            timeout_error <= 1'b1;
            write_enable  <= 1'b0;
            read_enable   <= 1'b0;
            state_q       <= StIdle;
          end
        end
        StWaitData: begin
          delay_cnt_q <= delay_cnt_q + 1'b1;
          if (delay_cnt_q == DelayLast) begin
            rsp_data  <= data_from_ram;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state_q   <= StRespond;
          end
        end
        StRespond: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
